stream_demux_1_4: RTL and testbench
===================================

# stream_demux_1_4

Registered 1-to-4 stream demultiplexer: one valid/ready input stream is steered to one of four valid/ready output channels. The target is chosen per beat by an explicit select or by an internal round-robin pointer. Each channel has a one-entry output register, so downstream consumers stall independently. It is the counterpart of the 4:1 multiplexer: it fans a shared producer out to four consumers in the streaming datapath.

## Interface
- `WIDTH`, default 4: data width per beat.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `mode`  input  1  target policy: 0 = directed (use `in_sel`), 1 = round-robin (use internal pointer).
- `in_valid`  input  1  input beat present.
- `in_ready`  output  1  block can accept the beat this cycle.
- `in_data`  input  WIDTH  input payload.
- `in_sel`  input  2  target channel in directed mode; ignored in round-robin mode.
- `out_valid`  output  4  per-channel beat present; bit k belongs to channel k.
- `out_ready`  input  4  per-channel consumer ready.
- `out_data`  output  4 x WIDTH  packed array [3:0][WIDTH-1:0], one payload per channel.
- `rr_ptr`  output  2  current round-robin pointer, for observation.

## Operation
- Target k = `in_sel` when `mode`=0, else `rr_ptr`.
- Slot k is full when `out_valid[k]`=1. `in_ready` = !`out_valid[k]` || `out_ready[k]`, where k is the current target.
- `in_ready` depends only on `mode`, `in_sel`, `rr_ptr`, `out_valid` and `out_ready`. It never depends on `in_valid`.
- Accept = `in_valid` && `in_ready`. On accept, slot k loads `in_data` and `out_valid[k]` is set.
- Drain of slot j = `out_valid[j]` && `out_ready[j]`. A drain with no fill of the same slot clears `out_valid[j]`.
- Fill and drain of the same slot in one cycle: the slot stays full and holds the new data.
- Non-target slots drain independently in the same cycle as an accept.
- While `out_valid[k]`=1 && `out_ready[k]`=0, `out_data[k]` is held stable.
- `out_data[k]` is don't-care while `out_valid[k]`=0, but resets to 0.
- Round-robin pointer:
  - Advances by 1 (3 wraps to 0) on each accept made in round-robin mode only.
  - Holds when there is no accept, and holds in directed mode.
  - A stalled target blocks round-robin. There is no skipping to a free channel.
- Switching `mode` between beats is legal. `rr_ptr` keeps its value across mode changes.

## Timing
- Reset (async assert, sampled release): `out_valid`=4'b0000, all `out_data`=0, `rr_ptr`=0. `in_ready` then evaluates to 1 combinationally.
- Reset mid-operation discards all buffered beats immediately. No partial state survives.
- Latency: a beat accepted at edge N appears on `out_valid[k]`/`out_data[k]` right after edge N, and can be consumed at edge N+1.
- Throughput: 1 beat/cycle to any channel whose consumer holds `out_ready`=1.
- Same-channel back-to-back traffic sustains full rate only via the fill-while-drain rule.
- All four slots full with all `out_ready`=0: `in_ready`=0 for every target, and no state changes.
- No combinational path from `in_valid` or `in_data` to any output.

## Structure
- Package `stream_demux_pkg`:
  - `N_CH` = 4;
  - `typedef logic [1:0] ch_idx_t`;
  - `typedef enum logic {MODE_DIRECTED, MODE_RR} demux_mode_t`.
- Sub-module `stream_slot`: one-entry valid/ready register with a fill-while-drain rule, parameterized by WIDTH. It is instantiated 4x by generate.
- The top level holds target selection, the one-hot fill decode, `in_ready` generation and the `rr_ptr` register.

## Test plan
- Reset, then directed beats 4'hA→ch2 and 4'h5→ch0 with all `out_ready`=1:
  - `out_valid` reads 0100 after the first edge and 0001 after the next;
  - data matches; `in_ready` stays 1.
- Round-robin mode, 6 beats 1..6 with consumers always ready:
  - channels 0,1,2,3,0,1 receive 1..6;
  - `rr_ptr` reads 2 at the end.
- Round-robin with `out_ready[1]`=0 and slot 1 full:
  - with `rr_ptr`=1, `in_ready`=0 and `rr_ptr` holds;
  - raising `out_ready[1]` accepts the beat and `rr_ptr` reaches 2.
- Directed streaming to ch3 with `out_ready[3]`=1, beats 7,8,9 on consecutive cycles:
  - all accepted with no bubble;
  - `out_data[3]` follows 7,8,9 one cycle late.
- All slots full and all `out_ready`=0, then `in_valid` held 10 cycles:
  - `in_ready`=0 throughout;
  - outputs stable; no state changes.
- Assert `rst` asynchronously mid-cycle while slots are full:
  - `out_valid` drops to 0000 and `rr_ptr` to 0 before the next edge;
  - first accept after release lands on ch0 in round-robin mode.

Source files
------------

// File: rtl/stream_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module : stream_demux_pkg
// Brief  : Shared types and constants for the 1-to-4 stream demultiplexer.
// Rev    : 1.0 - initial release
// ============================================================================
package stream_demux_pkg;

   localparam int N_CH = 4;

   typedef logic [1:0] ch_idx_t;

   typedef enum logic {
      MODE_DIRECTED = 1'b0,
      MODE_RR       = 1'b1
   } demux_mode_t;

   function automatic logic [N_CH-1:0] ch_onehot(input ch_idx_t idx);
      logic [N_CH-1:0] w_oh;
      w_oh      = '0;
      w_oh[idx] = 1'b1;
      return w_oh;
   endfunction

endpackage
`default_nettype wire

// File: rtl/stream_demux_if.sv
`default_nettype none
// ============================================================================
// Module : stream_demux_if
// Brief  : Input stream and four output channels of the 1-to-4 demultiplexer.
// Rev    : 1.0 - initial release
// ============================================================================
interface stream_demux_if #(
   parameter int WIDTH = 4
);
   import stream_demux_pkg::*;

   logic                        in_valid;
   logic                        in_ready;
   logic [WIDTH-1:0]            in_data;
   ch_idx_t                     in_sel;
   logic [N_CH-1:0]             out_valid;
   logic [N_CH-1:0]             out_ready;
   logic [N_CH-1:0][WIDTH-1:0]  out_data;

   // master drives the input stream and the consumer readies
   modport master (
      output in_valid, in_data, in_sel, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_sel, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface
`default_nettype wire

// File: rtl/stream_demux_1_4_slot.sv
`default_nettype none
// ============================================================================
// Module : stream_slot
// Brief  : One-entry valid/ready output register; a fill wins over a drain.
// Rev    : 1.0 - initial release
// ============================================================================
module stream_slot #(
   parameter int WIDTH = 4
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             fill_i,
   input  wire logic [WIDTH-1:0] data_i,
   input  wire logic             ready_i,
   output      logic             valid_o,
   output      logic [WIDTH-1:0] data_o
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q,  data_d;
   logic             w_drain;

   always_comb begin
      w_drain = valid_q & ready_i;
      valid_d = fill_i | (valid_q & ~w_drain);
      data_d  = fill_i ? data_i : data_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/stream_demux_1_4.sv
`default_nettype none
// ============================================================================
// Module : stream_demux_1_4
// Brief  : Registered 1-to-4 stream demux, directed or round-robin target.
// Rev    : 1.0 - initial release
// ============================================================================
module stream_demux_1_4
   import stream_demux_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  wire logic           clk,
   input  wire logic           rst,
   input  wire logic           mode,
   output      ch_idx_t        rr_ptr,
   stream_demux_if.slave       bus
);

   ch_idx_t         rr_ptr_q, rr_ptr_d;
   ch_idx_t         w_target;
   demux_mode_t     w_mode;
   logic            w_accept;
   logic [N_CH-1:0] w_fill;

   // in_ready is built only from state and select inputs, never from in_valid
   always_comb begin
      w_mode       = demux_mode_t'(mode);
      w_target     = (w_mode == MODE_RR) ? rr_ptr_q : bus.in_sel;
      bus.in_ready = ~bus.out_valid[w_target] | bus.out_ready[w_target];
      w_accept     = bus.in_valid & bus.in_ready;
      w_fill       = w_accept ? ch_onehot(w_target) : '0;
      rr_ptr_d     = rr_ptr_q;
      if (w_accept && (w_mode == MODE_RR)) begin
         rr_ptr_d = rr_ptr_q + 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign rr_ptr = rr_ptr_q;

   for (genvar k = 0; k < N_CH; k++) begin : g_slot
      stream_slot #(
         .WIDTH (WIDTH)
      ) u_slot (
         .clk     (clk),
         .rst     (rst),
         .fill_i  (w_fill[k]),
         .data_i  (bus.in_data),
         .ready_i (bus.out_ready[k]),
         .valid_o (bus.out_valid[k]),
         .data_o  (bus.out_data[k])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_stream_demux_1_4.sv
`default_nettype none
// ============================================================================
// Module : tb_stream_demux_1_4
// Brief  : Directed self-checking bench for stream_demux_1_4.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_stream_demux_1_4;
   import stream_demux_pkg::*;

   localparam int WIDTH = 4;

   logic    clk;
   logic    rst;
   logic    mode;
   ch_idx_t rr_ptr;
   int      n_assert;
   int      n_fail;

   stream_demux_if #(.WIDTH(WIDTH)) bus ();

   stream_demux_1_4 #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .mode   (mode),
      .rr_ptr (rr_ptr),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; mode = 1'b0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_sel = 2'd0; bus.out_ready = 4'h0;
      step(); step();
      rst = 1'b0;
      #1;
      n_assert++;
      if (bus.out_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_valid got %b want 0000", bus.out_valid); end
      n_assert++;
      if (bus.out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data got %h want 0000", bus.out_data); end
      n_assert++;
      if (rr_ptr !== 2'd0) begin n_fail++; $display("FAIL reset_rr got %0d want 0", rr_ptr); end
      n_assert++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", bus.in_ready); end
   endtask

   task automatic test_directed();
      mode = 1'b0; bus.out_ready = 4'hF;
      bus.in_valid = 1'b1; bus.in_data = 4'hA; bus.in_sel = 2'd2;
      step();
      n_assert++;
      if (bus.out_valid !== 4'b0100) begin n_fail++; $display("FAIL dir_valid1 got %b want 0100", bus.out_valid); end
      n_assert++;
      if (bus.out_data[2] !== 4'hA) begin n_fail++; $display("FAIL dir_data2 got %h want a", bus.out_data[2]); end
      n_assert++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL dir_ready1 got %b want 1", bus.in_ready); end
      bus.in_data = 4'h5; bus.in_sel = 2'd0;
      step();
      n_assert++;
      if (bus.out_valid !== 4'b0001) begin n_fail++; $display("FAIL dir_valid2 got %b want 0001", bus.out_valid); end
      n_assert++;
      if (bus.out_data[0] !== 4'h5) begin n_fail++; $display("FAIL dir_data0 got %h want 5", bus.out_data[0]); end
      n_assert++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL dir_ready2 got %b want 1", bus.in_ready); end
      n_assert++;
      if (rr_ptr !== 2'd0) begin n_fail++; $display("FAIL dir_rr_hold got %0d want 0", rr_ptr); end
      bus.in_valid = 1'b0;
      step();
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_v;
      mode = 1'b1; bus.out_ready = 4'hF; bus.in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.in_data = 4'(i + 1);
         step();
         exp_v = 4'b0001 << (i % 4);
         n_assert++;
         if (bus.out_valid !== exp_v) begin n_fail++; $display("FAIL rr_valid beat %0d got %b want %b", i, bus.out_valid, exp_v); end
         n_assert++;
         if (bus.out_data[i % 4] !== 4'(i + 1)) begin n_fail++; $display("FAIL rr_data beat %0d got %h want %h", i, bus.out_data[i % 4], 4'(i + 1)); end
      end
      bus.in_valid = 1'b0;
      n_assert++;
      if (rr_ptr !== 2'd2) begin n_fail++; $display("FAIL rr_ptr_end got %0d want 2", rr_ptr); end
      step();
   endtask

   task automatic test_rr_stall();
      // park a beat in slot 1 with its consumer stalled
      mode = 1'b0; bus.out_ready = 4'b1101;
      bus.in_valid = 1'b1; bus.in_sel = 2'd1; bus.in_data = 4'hB;
      step();
      mode = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.in_data = 4'(i);
         step();
      end
      bus.in_data = 4'hC;
      #1;
      n_assert++;
      if (rr_ptr !== 2'd1) begin n_fail++; $display("FAIL stall_rr_pre got %0d want 1", rr_ptr); end
      n_assert++;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready got %b want 0", bus.in_ready); end
      step();
      n_assert++;
      if (rr_ptr !== 2'd1) begin n_fail++; $display("FAIL stall_rr_hold got %0d want 1", rr_ptr); end
      n_assert++;
      if (bus.out_data[1] !== 4'hB) begin n_fail++; $display("FAIL stall_data1 got %h want b", bus.out_data[1]); end
      bus.out_ready = 4'hF;
      #1;
      n_assert++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready got %b want 1", bus.in_ready); end
      step();
      n_assert++;
      if (rr_ptr !== 2'd2) begin n_fail++; $display("FAIL stall_rr_adv got %0d want 2", rr_ptr); end
      n_assert++;
      if (bus.out_data[1] !== 4'hC || bus.out_valid[1] !== 1'b1) begin
         n_fail++; $display("FAIL stall_fill_drain got v=%b d=%h want v=1 d=c", bus.out_valid[1], bus.out_data[1]);
      end
      bus.in_valid = 1'b0;
      step();
   endtask

   task automatic test_back_to_back();
      logic [3:0] beats [3];
      beats[0] = 4'h7; beats[1] = 4'h8; beats[2] = 4'h9;
      mode = 1'b0; bus.out_ready = 4'hF; bus.in_sel = 2'd3; bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.in_data = beats[i];
         #1;
         n_assert++;
         if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready beat %0d got %b want 1", i, bus.in_ready); end
         step();
         n_assert++;
         if (bus.out_valid[3] !== 1'b1 || bus.out_data[3] !== beats[i]) begin
            n_fail++; $display("FAIL b2b_data beat %0d got v=%b d=%h want v=1 d=%h", i, bus.out_valid[3], bus.out_data[3], beats[i]);
         end
      end
      bus.in_valid = 1'b0;
      step();
   endtask

   task automatic test_full_stall();
      mode = 1'b0; bus.out_ready = 4'h0; bus.in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.in_sel = 2'(i); bus.in_data = 4'(i + 1);
         step();
      end
      bus.in_data = 4'hF;
      for (int i = 0; i < 10; i++) begin
         mode = i[0]; bus.in_sel = 2'(i);
         #1;
         n_assert++;
         if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready cyc %0d got %b want 0", i, bus.in_ready); end
         step();
         n_assert++;
         if (bus.out_valid !== 4'hF || bus.out_data !== 16'h4321 || rr_ptr !== 2'd2) begin
            n_fail++; $display("FAIL full_hold cyc %0d got v=%b d=%h rr=%0d want v=1111 d=4321 rr=2", i, bus.out_valid, bus.out_data, rr_ptr);
         end
      end
   endtask

   task automatic test_async_reset();
      #3;
      rst = 1'b1;
      #1;
      n_assert++;
      if (bus.out_valid !== 4'b0000 || rr_ptr !== 2'd0 || bus.out_data !== 16'h0000) begin
         n_fail++; $display("FAIL async_rst got v=%b rr=%0d d=%h want v=0000 rr=0 d=0000", bus.out_valid, rr_ptr, bus.out_data);
      end
      step();
      #2;
      rst = 1'b0;
      mode = 1'b1; bus.out_ready = 4'hF; bus.in_valid = 1'b1; bus.in_data = 4'h6;
      step();
      n_assert++;
      if (bus.out_valid !== 4'b0001 || bus.out_data[0] !== 4'h6 || rr_ptr !== 2'd1) begin
         n_fail++; $display("FAIL post_rst_accept got v=%b d0=%h rr=%0d want v=0001 d0=6 rr=1", bus.out_valid, bus.out_data[0], rr_ptr);
      end
      bus.in_valid = 1'b0;
      step();
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      test_reset();
      test_directed();
      test_round_robin();
      test_rr_stall();
      test_back_to_back();
      test_full_stall();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
